// File: rtl/mult_div_pkg.sv
// mult_div_pkg
// Shared definitions for the sequential multiply/divide unit: controller
// state encoding, operation encodings, iteration count and small
// two's-complement helpers used by the datapath.
package mult_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int ITERATIONS = 32;
  localparam int CNT_W      = $clog2(ITERATIONS);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);

  // Conditionally negate a 32-bit two's-complement value.
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  // Magnitude of a signed value; 0x80000000 maps to 0x80000000 (unsigned 2^31).
  function automatic logic [31:0] mag(input logic [31:0] v);
    return neg_if(v, v[31]);
  endfunction

endpackage

// File: rtl/mult_div_dp.sv
// mult_div_dp
// Iterative datapath shared by multiply and divide.
//   MULT: radix-2 Booth, {acc_hi, acc_lo, qm1} shifted right arithmetically
//         once per step; acc_hi carries one guard bit so +/- 2^31 partial
//         sums cannot overflow.
//   DIV : restoring division on magnitudes, {acc_hi, acc_lo} shifted left
//         once per step, quotient bits enter acc_lo from the right.
// Ports:
//   clk, reset   clock / asynchronous active-high reset
//   load         capture op, a, b and initialise the accumulators
//   step         perform one iteration of the latched operation
//   op, a, b     operation select and operands (used only with load)
//   res_hi/lo    final result with sign fix-up applied (valid after 32 steps)
module mult_div_dp
  import mult_div_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [32:0] acc_hi_q, acc_hi_d;
  logic [31:0] acc_lo_q, acc_lo_d;
  logic        qm1_q, qm1_d;
  logic [31:0] m_q, m_d;
  logic        op_q, op_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;

  logic [32:0] m_ext;
  logic [32:0] booth_sum;
  logic [32:0] div_shift;
  logic [32:0] div_diff;

  // Per-step arithmetic for both algorithms.
  always_comb begin
    m_ext = {m_q[31], m_q};
    case ({acc_lo_q[0], qm1_q})
      2'b01:   booth_sum = acc_hi_q + m_ext;
      2'b10:   booth_sum = acc_hi_q - m_ext;
      default: booth_sum = acc_hi_q;
    endcase
    // Remainder always stays below the divisor magnitude (<= 2^31), so the
    // shifted partial remainder fits in 33 bits.
    div_shift = {acc_hi_q[31:0], acc_lo_q[31]};
    div_diff  = div_shift - {1'b0, m_q};
  end

  always_comb begin
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    qm1_d    = qm1_q;
    m_d      = m_q;
    op_d     = op_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    if (load) begin
      op_d     = op;
      acc_hi_d = '0;
      qm1_d    = 1'b0;
      if (op == OP_MULT) begin
        acc_lo_d = b;
        m_d      = a;
        q_neg_d  = 1'b0;
        r_neg_d  = 1'b0;
      end else begin
        acc_lo_d = mag(a);
        m_d      = mag(b);
        q_neg_d  = a[31] ^ b[31];
        r_neg_d  = a[31];
      end
    end else if (step) begin
      if (op_q == OP_MULT) begin
        acc_hi_d = {booth_sum[32], booth_sum[32:1]};
        acc_lo_d = {booth_sum[0], acc_lo_q[31:1]};
        qm1_d    = acc_lo_q[0];
      end else if (div_shift >= {1'b0, m_q}) begin
        acc_hi_d = div_diff;
        acc_lo_d = {acc_lo_q[30:0], 1'b1};
      end else begin
        acc_hi_d = div_shift;
        acc_lo_d = {acc_lo_q[30:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      qm1_q    <= 1'b0;
      m_q      <= '0;
      op_q     <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
    end else begin
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      qm1_q    <= qm1_d;
      m_q      <= m_d;
      op_q     <= op_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
    end
  end

  // Quotient sign is the XOR of operand signs; remainder follows the dividend.
  // -2^31 / -1 yields magnitude 2^31 unnegated, i.e. 0x80000000.
  assign res_hi = (op_q == OP_MULT) ? acc_hi_q[31:0] : neg_if(acc_hi_q[31:0], r_neg_q);
  assign res_lo = (op_q == OP_MULT) ? acc_lo_q       : neg_if(acc_lo_q, q_neg_q);

endmodule

// File: rtl/mult_div_seq.sv
// mult_div_seq
// Sequential signed multiply/divide unit with HI/LO result registers.
// The controller FSM sequences mult_div_dp for 32 iterations and writes
// HI/LO on the edge that leaves DONE; status outputs are registered and
// therefore trail the state register by one cycle.
// Ports:
//   clk, reset   clock / asynchronous active-high reset
//   start, op    request pulse and operation (0 = MULT, 1 = DIV)
//   a, b         operands, captured when a request is accepted
//   busy         high from acceptance through the done cycle
//   done         one-cycle completion pulse
//   div_zero     one-cycle pulse with done on divide by zero
//   hi, lo       result registers
module mult_div_seq
  import mult_div_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               zero_q, zero_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;

  logic               dp_load;
  logic               dp_step;
  logic [31:0]        dp_hi;
  logic [31:0]        dp_lo;

  mult_div_dp u_dp (
    .clk    (clk),
    .reset  (reset),
    .load   (dp_load),
    .step   (dp_step),
    .op     (op),
    .a      (a),
    .b      (b),
    .res_hi (dp_hi),
    .res_lo (dp_lo)
  );

  // Next-state and registered-output logic. A request is only taken when
  // IDLE and busy has dropped, which keeps start ignored during the done
  // cycle; busy stays up through that cycle because done trails DONE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    zero_d     = zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    dp_load    = 1'b0;
    dp_step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !busy_q) begin
          dp_load = 1'b1;
          cnt_d   = '0;
          if (op == OP_DIV && b == '0) begin
            state_d = DONE;
            zero_d  = 1'b1;
          end else if (op == OP_DIV) begin
            state_d = DIV;
            zero_d  = 1'b0;
          end else begin
            state_d = MULT;
            zero_d  = 1'b0;
          end
        end
      end
      MULT, DIV: begin
        dp_step = 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!zero_q) begin
          hi_d = dp_hi;
          lo_d = dp_lo;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d     = (state_d != IDLE) || (state_q == DONE);
    done_d     = (state_q == DONE);
    div_zero_d = (state_q == DONE) && zero_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      zero_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      zero_q     <= zero_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_seq.sv
// tb_mult_div_seq
// Scoreboard bench for mult_div_seq: each accepted request pushes its
// expected HI/LO/div_zero and completion edge; a negedge monitor pops and
// compares whenever done is seen.
module tb_mult_div_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        zero;
    int          dueEdge;
  } expEntry_t;

  expEntry_t   sb[$];
  expEntry_t   got;
  int          testCount   = 0;
  int          failCount   = 0;
  int          edgeCount   = 0;
  int          busyRun     = 0;
  int          lastBusyRun = 0;
  logic        prevDone    = 1'b0;
  logic [31:0] modelHi     = '0;
  logic [31:0] modelLo     = '0;
  int          acceptEdge;

  mult_div_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edgeCount++;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, failed %0d", failCount);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Reference model: 64-bit arithmetic, truncating division (remainder
  // follows the dividend); divide by zero keeps the previous HI/LO.
  task automatic pushExpect(input logic opv, input logic [31:0] av,
                            input logic [31:0] bv, input int accEdge);
    expEntry_t e;
    longint    p;
    longint    q;
    longint    r;
    if (opv == 1'b0) begin
      p = longint'($signed(av)) * longint'($signed(bv));
      e.hi = p[63:32];
      e.lo = p[31:0];
      e.zero = 1'b0;
      e.dueEdge = accEdge + 33;
    end else if (bv == 32'd0) begin
      e.hi = modelHi;
      e.lo = modelLo;
      e.zero = 1'b1;
      e.dueEdge = accEdge + 1;
    end else begin
      q = longint'($signed(av)) / longint'($signed(bv));
      r = longint'($signed(av)) % longint'($signed(bv));
      e.hi = r[31:0];
      e.lo = q[31:0];
      e.zero = 1'b0;
      e.dueEdge = accEdge + 33;
    end
    modelHi = e.hi;
    modelLo = e.lo;
    sb.push_back(e);
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || busy) begin
      checkOutput("idleTimeout", {busy, 31'd0, 32'(sb.size())}, 64'd0);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic opv, input logic [31:0] av,
                               input logic [31:0] bv, output int accEdge);
    waitIdle();
    @(negedge clk);
    start = 1'b1;
    op    = opv;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    accEdge = edgeCount;
    start   = 1'b0;
    pushExpect(opv, av, bv, accEdge);
  endtask

  // Completion monitor plus busy-length tracking.
  always @(negedge clk) begin
    if (busy) begin
      busyRun++;
    end else if (busyRun != 0) begin
      lastBusyRun = busyRun;
      busyRun = 0;
    end
    if (prevDone) begin
      checkOutput("donePulse", 64'(done), 64'd0);
      checkOutput("divZeroPulse", 64'(div_zero), 64'd0);
    end
    if (done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpectedDone", 64'(done), 64'd0);
      end else begin
        got = sb.pop_front();
        checkOutput("hi", 64'(hi), 64'(got.hi));
        checkOutput("lo", 64'(lo), 64'(got.lo));
        checkOutput("divZero", 64'(div_zero), 64'(got.zero));
        checkOutput("latency", 64'(edgeCount), 64'(got.dueEdge));
      end
    end
    prevDone = done;
  end

  initial begin
    int doneEdge;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rop;
    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    checkOutput("rstDone", 64'(done), 64'd0);
    checkOutput("rstDivZero", 64'(div_zero), 64'd0);
    checkOutput("rstHi", 64'(hi), 64'd0);
    checkOutput("rstLo", 64'(lo), 64'd0);
    reset = 1'b0;

    applyStimulus(1'b0, 32'd7, 32'hFFFF_FFFD, acceptEdge);
    waitIdle();
    checkOutput("mulNegHi", 64'(hi), 64'hFFFF_FFFF);
    checkOutput("mulNegLo", 64'(lo), 64'hFFFF_FFEB);
    checkOutput("mulBusyLen", 64'(lastBusyRun), 64'd34);

    applyStimulus(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, acceptEdge);
    waitIdle();
    checkOutput("mulMaxHi", 64'(hi), 64'h3FFF_FFFF);
    checkOutput("mulMaxLo", 64'(lo), 64'h0000_0001);

    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, acceptEdge);
    waitIdle();
    checkOutput("divNegLo", 64'(lo), 64'hFFFF_FFFD);
    checkOutput("divNegHi", 64'(hi), 64'hFFFF_FFFF);

    // 0x33333333 * 0x55555556 = 0x11111111_22222222 seeds HI/LO
    applyStimulus(1'b0, 32'h3333_3333, 32'h5555_5556, acceptEdge);
    waitIdle();
    checkOutput("seedHi", 64'(hi), 64'h1111_1111);
    checkOutput("seedLo", 64'(lo), 64'h2222_2222);

    applyStimulus(1'b1, 32'd5, 32'd0, acceptEdge);
    waitIdle();
    checkOutput("div0Hi", 64'(hi), 64'h1111_1111);
    checkOutput("div0Lo", 64'(lo), 64'h2222_2222);
    checkOutput("div0BusyLen", 64'(lastBusyRun), 64'd2);

    applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, acceptEdge);
    waitIdle();
    checkOutput("ovfLo", 64'(lo), 64'h8000_0000);
    checkOutput("ovfHi", 64'(hi), 64'h0000_0000);

    applyStimulus(1'b0, 32'h8000_0000, 32'h8000_0000, acceptEdge);
    waitIdle();
    applyStimulus(1'b1, 32'h8000_0000, 32'd1, acceptEdge);
    waitIdle();

    // start held across the done cycle: only the following IDLE edge accepts
    applyStimulus(1'b0, 32'd12345, 32'hFFFF_FD5A, acceptEdge);
    for (int n = 0; n < 100 && !done; n++) @(negedge clk);
    if (!done) checkOutput("doneTimeout", 64'(done), 64'd1);
    start = 1'b1;
    op    = 1'b1;
    a     = 32'd1000;
    b     = 32'd7;
    doneEdge = edgeCount;
    @(posedge clk);
    @(posedge clk);
    #1;
    start = 1'b0;
    pushExpect(1'b1, 32'd1000, 32'd7, doneEdge + 2);
    waitIdle();

    // Reset mid-operation with an ignored start in between
    applyStimulus(1'b0, 32'h0000_1234, 32'h0000_5678, acceptEdge);
    while (edgeCount < acceptEdge + 4) @(negedge clk);
    start = 1'b1;
    op    = 1'b1;
    a     = 32'd9;
    b     = 32'd3;
    @(negedge clk);
    start = 1'b0;
    while (edgeCount < acceptEdge + 9) @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("midRstBusy", 64'(busy), 64'd0);
    checkOutput("midRstHi", 64'(hi), 64'd0);
    checkOutput("midRstLo", 64'(lo), 64'd0);
    checkOutput("midRstDone", 64'(done), 64'd0);
    sb.delete();
    modelHi = '0;
    modelLo = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("postRstHi", 64'(hi), 64'd0);

    applyStimulus(1'b0, 32'hFFFF_FFFB, 32'd9, acceptEdge);
    waitIdle();

    for (int i = 0; i < 8; i++) begin
      rop = 1'($urandom_range(0, 1));
      ra  = $urandom;
      rb  = (i == 5) ? 32'd0 : $urandom;
      if (i == 6) rb = 32'(($urandom_range(1, 50)));
      applyStimulus(rop, ra, rb, acceptEdge);
    end
    waitIdle();

    checkOutput("queueEmpty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
